// File: rtl/evm_pkg.sv
// Shared types and constants for the EVM voting FSM and the vote tally block.
package evm_pkg;

  localparam int NUM_PARTY = 4;

  // Officer key position, also used by the voting FSM
  localparam logic MODE_VOTE   = 1'b1;
  localparam logic MODE_RESULT = 1'b0;

  typedef logic [1:0] party_t;

  typedef enum logic [1:0] {
    VOTE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/evm_sat_counter.sv
// Per-party tally: counts up on inc and sticks at all-ones; clr has priority.
module evm_sat_counter
  import evm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_reg;

  // Counter register: clear wins, increment stops at the ceiling
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign count = count_reg;
  assign sat   = (count_reg == CNT_MAX);

endmodule

// File: rtl/evm_vote_tally.sv
// Vote tally: four saturating party counters, running total, sticky overflow,
// and a 4-cycle sequential winner/tie scan entered when the officer selects
// result mode. Counts are only visible while results are being held.
module evm_vote_tally
  import evm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             vote_valid,
  input  logic [1:0]       incr_party_vote,
  input  logic [1:0]       result_sel,
  input  logic             clear_req,
  output logic [CNT_W-1:0] disp_count,
  output logic [CNT_W+1:0] total_votes,
  output logic [1:0]       winner,
  output logic             winner_valid,
  output logic             tie,
  output logic             overflow,
  output logic             busy
);

  state_t state_reg, state_next;
  party_t idx_reg, idx_next;

  logic [CNT_W-1:0] cnt [NUM_PARTY];
  logic [NUM_PARTY-1:0] sat;
  logic [NUM_PARTY-1:0] inc;

  logic [CNT_W-1:0] best_reg, best_next;
  party_t           best_idx_reg, best_idx_next;
  logic             tie_scan_reg, tie_scan_next;
  logic [CNT_W-1:0] cur_cnt;

  logic [CNT_W+1:0] total_reg;
  logic             overflow_reg;
  party_t           winner_reg;
  logic             tie_reg;
  logic             winner_valid_reg;

  logic accept;
  logic vote_sat;
  logic do_clear;
  logic scan_last;

  // A vote only counts while the booth is open; the mode-change cycle drops it
  assign accept    = (state_reg == VOTE) && (mode == MODE_VOTE) && vote_valid;
  assign vote_sat  = sat[incr_party_vote];
  // Clearing is only possible once results are frozen, never mid-election
  assign do_clear  = (state_reg == HOLD) && clear_req;
  assign scan_last = (state_reg == SCAN) && (idx_reg == party_t'(NUM_PARTY - 1));

  generate
    for (genvar gi = 0; gi < NUM_PARTY; gi++) begin : g_party
      assign inc[gi] = accept && (incr_party_vote == party_t'(gi));

      evm_sat_counter #(
        .CNT_W(CNT_W)
      ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (inc[gi]),
        .clr  (do_clear),
        .count(cnt[gi]),
        .sat  (sat[gi])
      );
    end
  endgenerate

  assign cur_cnt = cnt[idx_reg];

  // State register for the vote/scan/hold controller and scan index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= VOTE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Next-state logic and the running-maximum step of the scan
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    best_next     = best_reg;
    best_idx_next = best_idx_reg;
    tie_scan_next = tie_scan_reg;
    case (state_reg)
      VOTE: begin
        if (mode == MODE_RESULT) begin
          state_next = SCAN;
          idx_next   = '0;
        end
      end
      SCAN: begin
        idx_next = idx_reg + party_t'(1);
        if (idx_reg == '0) begin
          best_next     = cur_cnt;
          best_idx_next = '0;
          tie_scan_next = 1'b0;
        end else if (cur_cnt > best_reg) begin
          best_next     = cur_cnt;
          best_idx_next = idx_reg;
          tie_scan_next = 1'b0;
        end else if (cur_cnt == best_reg) begin
          // Lower index keeps the win; only the tie flag is raised
          tie_scan_next = 1'b1;
        end
        if (scan_last) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (!clear_req && (mode == MODE_VOTE)) begin
          state_next = VOTE;
        end
      end
      default: begin
        state_next = VOTE;
        idx_next   = '0;
      end
    endcase
  end

  // Scan working registers; a reset mid-scan discards any partial result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_reg     <= '0;
      best_idx_reg <= '0;
      tie_scan_reg <= 1'b0;
    end else begin
      best_reg     <= best_next;
      best_idx_reg <= best_idx_next;
      tie_scan_reg <= tie_scan_next;
    end
  end

  // Published result: loaded on the final scan step, invalidated on clear or resume
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      winner_reg       <= '0;
      tie_reg          <= 1'b0;
      winner_valid_reg <= 1'b0;
    end else if (scan_last) begin
      winner_reg       <= best_idx_next;
      tie_reg          <= tie_scan_next;
      winner_valid_reg <= 1'b1;
    end else if (do_clear) begin
      winner_valid_reg <= 1'b0;
    end else if ((state_reg == HOLD) && (mode == MODE_VOTE)) begin
      winner_valid_reg <= 1'b0;
    end
  end

  // Running total and sticky overflow track only the votes the counters took
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (do_clear) begin
      total_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (accept) begin
      if (vote_sat) begin
        overflow_reg <= 1'b1;
      end else begin
        total_reg <= total_reg + (CNT_W + 2)'(1);
      end
    end
  end

  assign disp_count   = (state_reg == HOLD) ? cnt[result_sel] : '0;
  assign total_votes  = (state_reg == HOLD) ? total_reg : '0;
  assign busy         = (state_reg == SCAN);
  assign winner       = winner_reg;
  assign tie          = tie_reg;
  assign winner_valid = winner_valid_reg;
  assign overflow     = overflow_reg;

endmodule

// File: tb/tb_evm_vote_tally.sv
// Scoreboard bench for evm_vote_tally (narrow counters so saturation is reachable).
module tb_evm_vote_tally;
  import evm_pkg::*;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          mode;
  logic          vote_valid;
  logic [1:0]    incr_party_vote;
  logic [1:0]    result_sel;
  logic          clear_req;
  logic [CW-1:0] disp_count;
  logic [CW+1:0] total_votes;
  logic [1:0]    winner;
  logic          winner_valid;
  logic          tie;
  logic          overflow;
  logic          busy;

  always #5 clk = ~clk;

  evm_vote_tally #(.CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .mode           (mode),
    .vote_valid     (vote_valid),
    .incr_party_vote(incr_party_vote),
    .result_sel     (result_sel),
    .clear_req      (clear_req),
    .disp_count     (disp_count),
    .total_votes    (total_votes),
    .winner         (winner),
    .winner_valid   (winner_valid),
    .tie            (tie),
    .overflow       (overflow),
    .busy           (busy)
  );

  typedef struct {
    string name;
    int    winner;
    int    tie;
    int    total;
    int    ovf;
  } scan_exp_t;

  typedef struct {
    string name;
    int    disp;
    int    total;
    int    winner;
    int    tie;
    int    wv;
    int    ovf;
    int    busy;
    bit    care_win;
  } snap_exp_t;

  scan_exp_t scan_q[$];
  snap_exp_t snap_q[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   snap_req = 1'b0;
  bit   end_req  = 1'b0;
  logic wv_prev  = 1'b0;
  int   busy_run = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: scan results on winner_valid rising, snapshots on request, busy length
  always @(negedge clk) begin
    if (winner_valid && !wv_prev) begin
      if (scan_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got winner=%0d tie=%0d, expected no result", winner, tie);
      end else begin
        scan_exp_t e;
        e = scan_q.pop_front();
        chk({e.name, ".winner"},   int'(winner),      e.winner);
        chk({e.name, ".tie"},      int'(tie),         e.tie);
        chk({e.name, ".total"},    int'(total_votes), e.total);
        chk({e.name, ".overflow"}, int'(overflow),    e.ovf);
        $display("scan %s: winner=%0d tie=%0d total=%0d overflow=%0d", e.name, winner, tie, total_votes, overflow);
      end
    end
    wv_prev <= winner_valid;

    if (reset) begin
      busy_run <= 0;
    end else if (busy) begin
      busy_run <= busy_run + 1;
    end else begin
      if (busy_run != 0) chk("busy_cycles", busy_run, 4);
      busy_run <= 0;
    end

    if (snap_req) begin
      if (snap_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL snap_queue: got empty queue, expected an entry");
      end else begin
        snap_exp_t s;
        s = snap_q.pop_front();
        chk({s.name, ".disp_count"},   int'(disp_count),   s.disp);
        chk({s.name, ".total_votes"},  int'(total_votes),  s.total);
        chk({s.name, ".winner_valid"}, int'(winner_valid), s.wv);
        chk({s.name, ".overflow"},     int'(overflow),     s.ovf);
        chk({s.name, ".busy"},         int'(busy),         s.busy);
        if (s.care_win) begin
          chk({s.name, ".winner"}, int'(winner), s.winner);
          chk({s.name, ".tie"},    int'(tie),    s.tie);
        end
        $display("snap %s: sel=%0d disp=%0d total=%0d wv=%0d ovf=%0d busy=%0d", s.name, result_sel, disp_count, total_votes, winner_valid, overflow, busy);
      end
    end

    if (end_req) begin
      chk("scan_queue_drained", scan_q.size(), 0);
      chk("snap_queue_drained", snap_q.size(), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vote(input int p);
    vote_valid      = 1'b1;
    incr_party_vote = 2'(p);
    tick();
    vote_valid = 1'b0;
  endtask

  task automatic snap(input string name, input int sel, input int disp, input int total,
                      input int w, input int t, input int wv, input int ovf, input int bsy,
                      input bit care);
    snap_exp_t s;
    result_sel = 2'(sel);
    s.name = name; s.disp = disp; s.total = total; s.winner = w; s.tie = t;
    s.wv = wv; s.ovf = ovf; s.busy = bsy; s.care_win = care;
    snap_q.push_back(s);
    snap_req = 1'b1;
    @(negedge clk);
    #1;
    snap_req = 1'b0;
  endtask

  // Enter result mode with a vote that must be dropped, poke votes and mode during the scan
  task automatic run_scan(input string name, input int w, input int t, input int total, input int ovf);
    scan_exp_t e;
    e.name = name; e.winner = w; e.tie = t; e.total = total; e.ovf = ovf;
    scan_q.push_back(e);
    mode            = MODE_RESULT;
    vote_valid      = 1'b1;
    incr_party_vote = 2'd0;
    tick();
    mode = MODE_VOTE;
    tick();
    vote_valid = 1'b0;
    mode       = MODE_RESULT;
    tick();
    tick();
    tick();
  endtask

  task automatic go_vote();
    mode = MODE_VOTE;
    tick();
  endtask

  task automatic do_clear();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    mode            = MODE_VOTE;
    vote_valid      = 1'b0;
    incr_party_vote = 2'd0;
    result_sel      = 2'd0;
    clear_req       = 1'b0;
    tick();
    snap("reset", 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    reset = 1'b0;
    tick();

    // Basic election: parties 0,1,1,2,3,1
    vote(0); vote(1); vote(1); vote(2); vote(3); vote(1);
    do_clear();
    snap("vote_gated", 1, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    run_scan("basic", 1, 0, 6, 0);
    snap("basic_p1", 1, 3, 6, 1, 0, 1, 0, 0, 1'b1);
    snap("basic_p3", 3, 1, 6, 1, 0, 1, 0, 0, 1'b1);
    snap("basic_p0", 0, 1, 6, 1, 0, 1, 0, 0, 1'b1);

    // Clear in HOLD, then a single vote for party 2
    do_clear();
    snap("cleared", 1, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    go_vote();
    vote(2);
    run_scan("single_p2", 2, 0, 1, 0);

    // Tie between parties 0 and 2
    do_clear();
    go_vote();
    vote(0); vote(0); vote(2); vote(2); vote(3);
    run_scan("tie_p0_p2", 0, 1, 5, 0);
    snap("tie_p2", 2, 2, 5, 0, 1, 1, 0, 0, 1'b1);

    // No votes at all
    do_clear();
    go_vote();
    run_scan("no_votes", 0, 1, 0, 0);

    // Saturation of party 3
    do_clear();
    go_vote();
    vote(3); vote(3); vote(3); vote(3); vote(3);
    snap("sat_voting", 3, 0, 0, 0, 0, 0, 1, 0, 1'b0);
    run_scan("sat", 3, 0, 3, 1);
    snap("sat_p3", 3, 3, 3, 3, 0, 1, 1, 0, 1'b1);
    go_vote();
    vote(0);
    run_scan("sat_resume", 3, 0, 4, 1);
    snap("sat_resume_p0", 0, 1, 4, 3, 0, 1, 1, 0, 1'b1);

    // Reset in the middle of a scan
    go_vote();
    vote(1); vote(1);
    mode = MODE_RESULT;
    tick();
    tick();
    tick();
    reset = 1'b1;
    snap("reset_mid_scan", 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    reset = 1'b0;
    mode  = MODE_VOTE;
    tick();
    vote(2);
    run_scan("after_reset", 2, 0, 1, 0);
    snap("after_reset_p1", 1, 0, 1, 2, 0, 1, 0, 0, 1'b1);

    tick();
    end_req = 1'b1;
    @(negedge clk);
    #1;
    end_req = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/evm_vote_tally.md
Name: evm_vote_tally

Overview:
- Downstream of the EVM voting FSM. Consumes its one-cycle vote strobe and 2-bit party index.
- Keeps one saturating tally per party (4 parties) and a running total.
- When the officer switches to result mode, runs a 4-cycle sequential winner/tie scan and exposes results for display.
- Counts are hidden while voting is open.

Parameters:
- CNT_W, 8, width of each per-party counter; saturates at 2^CNT_W-1

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- mode  input  1  1 = voting open, 0 = result mode
- vote_valid  input  1  one-cycle strobe from voting FSM: cast one vote
- incr_party_vote  input  2  party index 0..3, qualified by vote_valid
- result_sel  input  2  party whose count is driven on disp_count
- clear_req  input  1  officer clear of all tallies; honoured only in HOLD
- disp_count  output  CNT_W  count of party result_sel (HOLD only, else 0)
- total_votes  output  CNT_W+2  sum of accepted votes (HOLD only, else 0)
- winner  output  2  index of party with highest count
- winner_valid  output  1  winner/tie are valid
- tie  output  1  two or more parties share the maximum count
- overflow  output  1  sticky: a vote was dropped because its counter was saturated
- busy  output  1  scan in progress

Behaviour:
- Reset: asynchronous, active-high. Clears all counters, total, overflow, best-tracking registers and the FSM (to VOTE). All outputs 0. Reset during SCAN aborts the scan, no partial result is kept.
- States: VOTE, SCAN, HOLD.
- VOTE
  - A vote is accepted at a rising edge iff state==VOTE, mode==1 and vote_valid==1.
  - An accepted vote increments cnt[incr_party_vote] and total_votes by 1.
  - If that counter is already at 2^CNT_W-1: cnt and total stay unchanged, overflow is set (sticky until reset or clear).
  - mode==0 sampled at an edge: transition to SCAN. A vote_valid in that same cycle is dropped without setting overflow.
- SCAN
  - Lasts exactly 4 cycles, idx = 0..3. busy=1. All votes ignored.
  - idx 0: best=cnt[0], best_idx=0, tie_r=0.
  - idx 1..3: if cnt[idx] > best, then best=cnt[idx], best_idx=idx, tie_r=0. If cnt[idx] == best, tie_r=1. Lower-index party wins equality.
  - mode returning to 1 during SCAN is ignored; the scan always completes.
  - Entering SCAN at edge k gives winner/tie/winner_valid=1 after edge k+4, in the same cycle state becomes HOLD.
- HOLD
  - disp_count = cnt[result_sel], combinational from registers.
  - total_votes is driven; winner/tie/winner_valid are held.
  - clear_req==1: zero all counters, total and overflow; winner_valid <- 0; stay in HOLD. disp_count reads 0 next cycle.
  - mode==1 at an edge: back to VOTE, winner_valid <- 0. Counts are preserved and voting resumes accumulating.
  - clear_req in VOTE or SCAN is ignored (tamper protection).
- All-zero tallies: scan yields winner=0, tie=1.
- Width rules:
  - total_votes is CNT_W+2 bits, which cannot overflow since it is at most 4*(2^CNT_W-1).
  - Comparisons are unsigned.
- Outputs winner, tie, overflow and winner_valid are registered. disp_count, total_votes and busy are decoded from registers.

Decomposition:
- Shared package evm_pkg:
  - state enum {VOTE, SCAN, HOLD}
  - party index type (2 bits)
  - NUM_PARTY=4
  - MODE_VOTE=1 / MODE_RESULT=0 constants; the voting FSM reuses these
- Sub-module evm_sat_counter (CNT_W param)
  - inputs: inc, clr
  - outputs: count, sat
  - instantiated 4x; the top keeps the FSM, scan datapath, total and overflow.

Test Plan:
- Reset, mode=1, strobe parties 0,1,1,2,3,1, then mode=0 -> busy high 4 cycles; then winner=1, tie=0, winner_valid=1, total_votes=6, disp_count(sel=1)=3, disp_count(sel=3)=1.
- Votes p0 x2, p2 x2, p3 x1 -> scan gives winner=0, tie=1. Also check no-vote case: winner=0, tie=1.
- CNT_W=2: five votes to p3 -> cnt[3]=3, total=3, overflow=1. Overflow persists after a mode toggle; vote to p0 still counts.
- During VOTE: disp_count=0, total_votes=0, clear_req ignored. vote_valid in the mode=0 cycle dropped. Votes during SCAN dropped; total unchanged after scan.
- In HOLD, clear_req=1 -> all counts 0, overflow=0, winner_valid=0. Next, mode=1 plus a vote to p2, then mode=0 -> winner=2, total=1.
- Assert reset at scan cycle 2 -> all outputs 0 immediately, state VOTE. Subsequent votes count from zero.
